quiz_round: RTL

QUIZ_ROUND -- requirements
Module: quiz_round

---
 rtl/quiz_round.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/quiz_round.sv
// Purpose: quiz-show round controller: arm, countdown, buzzer lock-out, verdict scoring.
// Latency: every input event is acted on at the next rising clk edge; outputs are registered.
// Backpressure: none; edges arriving in states that do not use them are dropped.
module quiz_round #(
  parameter int TICK_CYCLES = 100000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       is_set_over,
  input  logic [5:0] num_people,
  input  logic [5:0] count_seconds,
  input  logic [5:0] corrcet_point,
  input  logic [5:0] mistake_point,
  input  logic       start_btn,
  input  logic [3:0] player_btn,
  input  logic       judge_right,
  input  logic       judge_wrong,
  output logic [2:0] round_state,
  output logic [2:0] winner_id,
  output logic [5:0] time_left,
  output logic       timeout_pulse,
  output logic [7:0] score0,
  output logic [7:0] score1,
  output logic [7:0] score2,
  output logic [7:0] score3
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    READY  = 3'd1,
    ARMED  = 3'd2,
    ANSWER = 3'd3,
    SCORE  = 3'd4
  } state_t;

  // Configuration snapshot taken when leaving IDLE.
  typedef struct packed {
    logic [5:0] num;
    logic [5:0] secs;
    logic [5:0] cp;
    logic [5:0] mp;
  } cfg_t;

  localparam int PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_CYCLES - 1);

  state_t        state;
  cfg_t          cfg;
  logic [PW-1:0] presc;
  logic [7:0]    scores [4];

  logic       start_q, right_q, wrong_q;
  logic [3:0] player_q;
  logic       start_edge, right_edge, wrong_edge;
  logic [3:0] player_edge;
  logic [3:0] eligible;
  logic [2:0] buzz_id;
  logic [1:0] widx;
  logic [8:0] add9, sub9;

  assign start_edge  = start_btn & ~start_q;
  assign right_edge  = judge_right & ~right_q;
  assign wrong_edge  = judge_wrong & ~wrong_q;
  assign player_edge = player_btn & ~player_q;

  // Only players seated in this configuration may buzz; lowest index wins ties.
  always_comb begin
    eligible = 4'b0000;
    buzz_id  = 3'd0;
    for (int i = 0; i < 4; i++) begin
      eligible[i] = player_edge[i] && (cfg.num > 6'(i));
    end
    for (int i = 3; i >= 0; i--) begin
      if (eligible[i]) buzz_id = 3'(i + 1);
    end
  end

  // 9-bit add/subtract on the locked player's score so carry/borrow drive saturation.
  assign widx = 2'(winner_id - 3'd1);
  assign add9 = {1'b0, scores[widx]} + {3'b000, cfg.cp};
  assign sub9 = {1'b0, scores[widx]} - {3'b000, cfg.mp};

  assign round_state = state;
  assign score0 = scores[0];
  assign score1 = scores[1];
  assign score2 = scores[2];
  assign score3 = scores[3];

  // Edge-detect history for the debounced level buttons.
  always_ff @(posedge clk) begin
    if (rst) begin
      start_q  <= 1'b0;
      right_q  <= 1'b0;
      wrong_q  <= 1'b0;
      player_q <= 4'b0000;
    end else begin
      start_q  <= start_btn;
      right_q  <= judge_right;
      wrong_q  <= judge_wrong;
      player_q <= player_btn;
    end
  end

  // Round state machine with countdown, buzzer lock and score update.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cfg           <= '0;
      presc         <= '0;
      winner_id     <= 3'd0;
      time_left     <= 6'd0;
      timeout_pulse <= 1'b0;
      for (int i = 0; i < 4; i++) scores[i] <= 8'd0;
    end else begin
      timeout_pulse <= 1'b0;
      if (state != IDLE && !is_set_over) begin
        // Configuration withdrawn: abandon the round, keep scores and clock.
        state     <= IDLE;
        winner_id <= 3'd0;
      end else begin
        case (state)
          IDLE: begin
            if (is_set_over) begin
              cfg   <= '{num: num_people, secs: count_seconds,
                         cp: corrcet_point, mp: mistake_point};
              for (int i = 0; i < 4; i++) scores[i] <= 8'd0;
              state <= READY;
            end
          end
          READY: begin
            if (start_edge) begin
              time_left <= cfg.secs;
              presc     <= '0;
              state     <= ARMED;
            end
          end
          ARMED: begin
            if (buzz_id != 3'd0) begin
              // A buzz beats a coincident final tick; the countdown freezes.
              winner_id <= buzz_id;
              state     <= ANSWER;
            end else if (presc == PRESC_LAST) begin
              presc <= '0;
              if (time_left <= 6'd1) begin
                time_left     <= 6'd0;
                timeout_pulse <= 1'b1;
                state         <= READY;
              end else begin
                time_left <= time_left - 6'd1;
              end
            end else begin
              presc <= presc + 1'b1;
            end
          end
          ANSWER: begin
            // Simultaneous verdicts are contradictory and are ignored.
            if (right_edge && !wrong_edge) begin
              scores[widx] <= add9[8] ? 8'd255 : add9[7:0];
              state        <= SCORE;
            end else if (wrong_edge && !right_edge) begin
              scores[widx] <= sub9[8] ? 8'd0 : sub9[7:0];
              state        <= SCORE;
            end
          end
          SCORE: begin
            winner_id <= 3'd0;
            state     <= READY;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
